// File: rtl/student_tlul_sram.sv
// TL-UL responder with word-addressed SRAM and in-order response queue.
// Bad requests are answered with d_error and never touch memory.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        error;
    logic [31:0] data;
  } rsp_t;
endpackage

module student_tlul_sram
  import tlul_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h1000_0000,
  parameter int unsigned Depth    = 1024,
  parameter int unsigned RspDepth = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam logic [31:0] WinMask = 32'(Depth * 4 - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);

  logic [31:0]     mem_q [Depth];
  rsp_t            q_q [RspDepth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            full, empty, push, pop;
  logic [IdxW-1:0] idx;
  logic            op_get, op_pf, op_pp;
  logic            in_range, misalign, err, we;
  rsp_t            rsp_d;
  logic            unused_ok;

  assign unused_ok = ^tl_i.a_param;

  assign full  = (cnt_q == CntW'(RspDepth));
  assign empty = (cnt_q == '0);
  assign push  = tl_i.a_valid && !full;
  assign pop   = !empty && tl_i.d_ready;

  assign idx      = tl_i.a_address[IdxW+1:2];
  assign in_range = (tl_i.a_address & ~WinMask) == BaseAddr;
  assign op_get   = (tl_i.a_opcode == Get);
  assign op_pf    = (tl_i.a_opcode == PutFullData);
  assign op_pp    = (tl_i.a_opcode == PutPartialData);

  // Request decode: alignment, legality and the response entry to push
  always_comb begin
    misalign = 1'b0;
    unique case (tl_i.a_size)
      2'd1:    misalign = tl_i.a_address[0];
      2'd2:    misalign = |tl_i.a_address[1:0];
      default: misalign = 1'b0;
    endcase
    err = !(op_get || op_pf || op_pp) || !in_range
       || (tl_i.a_size == 2'd3) || misalign
       || (op_pf && tl_i.a_size == 2'd2 && tl_i.a_mask != 4'hF);
    we  = push && !err && (op_pf || op_pp);
    rsp_d        = '0;
    rsp_d.opcode = op_get ? AccessAckData : AccessAck;
    rsp_d.size   = tl_i.a_size;
    rsp_d.source = tl_i.a_source;
    rsp_d.error  = err;
    rsp_d.data   = (op_get && !err) ? mem_q[idx] : 32'h0;
  end

  // Byte-lane SRAM write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (tl_i.a_mask[i]) mem_q[idx][8*i +: 8] <= tl_i.a_data[8*i +: 8];
      end
    end
  end

  // Response queue storage
  always_ff @(posedge clk_i) begin
    if (push) q_q[wr_ptr_q] <= rsp_d;
  end

  // Pointer and occupancy next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // D channel driven from queue head; zero when empty
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = !full;
    if (!empty) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = q_q[rd_ptr_q].opcode;
      tl_o.d_size   = q_q[rd_ptr_q].size;
      tl_o.d_source = q_q[rd_ptr_q].source;
      tl_o.d_error  = q_q[rd_ptr_q].error;
      tl_o.d_data   = q_q[rd_ptr_q].data;
    end
  end

endmodule

// File: tb/tb_student_tlul_sram.sv
// Directed testbench for student_tlul_sram.
// Drives and samples on the falling edge.
module tb_student_tlul_sram;
  import tlul_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;

  int checks = 0;
  int failures = 0;

  logic [2:0]  r_op;
  logic [1:0]  r_size;
  logic [7:0]  r_src;
  logic        r_err;
  logic [31:0] r_data;

  student_tlul_sram dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tl_i   (tl_i),
    .tl_o   (tl_o)
  );

  always #5 clk = ~clk;

  task automatic set_a(input logic [2:0] op, input logic [31:0] addr,
                       input logic [1:0] size, input logic [3:0] mask,
                       input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = addr;
    tl_i.a_size    = size;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [1:0] size, input logic [3:0] mask,
                       input logic [31:0] data, input logic [7:0] src);
    int n = 0;
    set_a(op, addr, size, mask, data, src);
    while (!tl_o.a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL issue_timeout a_ready=%0b required=1", tl_o.a_ready);
    end
    @(posedge clk);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
  endtask

  task automatic take();
    int n = 0;
    while (!tl_o.d_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL take_timeout d_valid=%0b required=1", tl_o.d_valid);
    end
    r_op   = tl_o.d_opcode;
    r_size = tl_o.d_size;
    r_src  = tl_o.d_source;
    r_err  = tl_o.d_error;
    r_data = tl_o.d_data;
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    tl_i.d_ready = 1'b0;
  endtask

  task automatic test_reset();
    tl_i = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tl_o !== 61'(1)) begin
      failures++;
      $display("FAIL reset_tl_o got=%h required=%h", tl_o, 61'(1));
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(Get, 32'h1000_0000, 2'd2, 4'hF, 32'h0, 8'h01);
    issue(Get, 32'h1000_0004, 2'd2, 4'hF, 32'h0, 8'h02);
    checks++;
    if (tl_o.a_ready !== 1'b0 || tl_o.d_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefull a_ready=%b d_valid=%b required 0 1",
               tl_o.a_ready, tl_o.d_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tl_o.d_valid !== 1'b0 || tl_o.a_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_async d_valid=%b a_ready=%b required 0 1",
               tl_o.d_valid, tl_o.a_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tl_o !== 61'(1)) begin
      failures++;
      $display("FAIL reset_release tl_o got=%h required=%h", tl_o, 61'(1));
    end
  endtask

  task automatic test_put_get();
    issue(PutFullData, 32'h1000_0010, 2'd2, 4'hF, 32'hDEAD_BEEF, 8'h30);
    take();
    checks++;
    if (r_op !== AccessAck || r_src !== 8'h30 || r_err !== 1'b0
        || r_data !== 32'h0 || r_size !== 2'd2) begin
      failures++;
      $display("FAIL putfull_rsp op=%0d src=%h err=%b data=%h size=%0d required 0 30 0 0 2",
               r_op, r_src, r_err, r_data, r_size);
    end
    issue(Get, 32'h1000_0010, 2'd2, 4'hF, 32'h0, 8'h31);
    take();
    checks++;
    if (r_op !== AccessAckData || r_src !== 8'h31 || r_err !== 1'b0
        || r_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL get_rsp op=%0d src=%h err=%b data=%h required 1 31 0 deadbeef",
               r_op, r_src, r_err, r_data);
    end
  endtask

  task automatic test_partial();
    issue(PutPartialData, 32'h1000_0010, 2'd2, 4'b0101, 32'h1122_3344, 8'h32);
    take();
    checks++;
    if (r_op !== AccessAck || r_err !== 1'b0) begin
      failures++;
      $display("FAIL partial_rsp op=%0d err=%b required 0 0", r_op, r_err);
    end
    issue(Get, 32'h1000_0010, 2'd2, 4'h0, 32'h0, 8'h33);
    take();
    checks++;
    if (r_data !== 32'hDE22_BE44 || r_err !== 1'b0) begin
      failures++;
      $display("FAIL partial_data got=%h err=%b required=de22be44 0", r_data, r_err);
    end
  endtask

  task automatic test_raw();
    tl_i.d_ready = 1'b1;
    set_a(PutFullData, 32'h1000_0014, 2'd2, 4'hF, 32'hA5A5_5A5A, 8'h50);
    @(negedge clk);
    set_a(Get, 32'h1000_0014, 2'd2, 4'hF, 32'h0, 8'h51);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    checks++;
    if (tl_o.d_data !== 32'hA5A5_5A5A || tl_o.d_source !== 8'h51
        || tl_o.d_opcode !== AccessAckData) begin
      failures++;
      $display("FAIL raw_get data=%h src=%h op=%0d required a5a55a5a 51 1",
               tl_o.d_data, tl_o.d_source, tl_o.d_opcode);
    end
    @(negedge clk);
    tl_i.d_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(PutFullData, 32'h1000_0020, 2'd2, 4'hF, 32'h0000_AAAA, 8'h60);
    take();
    issue(PutFullData, 32'h1000_0024, 2'd2, 4'hF, 32'h0000_BBBB, 8'h61);
    take();
    issue(PutFullData, 32'h1000_0028, 2'd2, 4'hF, 32'h0000_CCCC, 8'h62);
    take();
    set_a(Get, 32'h1000_0020, 2'd2, 4'hF, 32'h0, 8'h70);
    @(negedge clk);
    set_a(Get, 32'h1000_0024, 2'd2, 4'hF, 32'h0, 8'h71);
    @(negedge clk);
    set_a(Get, 32'h1000_0028, 2'd2, 4'hF, 32'h0, 8'h72);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tl_o.a_ready !== 1'b0 || tl_o.d_valid !== 1'b1
          || tl_o.d_data !== 32'h0000_AAAA || tl_o.d_source !== 8'h70) begin
        failures++;
        $display("FAIL b2b_stall%0d a_ready=%b d_valid=%b data=%h src=%h required 0 1 0000aaaa 70",
                 i, tl_o.a_ready, tl_o.d_valid, tl_o.d_data, tl_o.d_source);
      end
      @(negedge clk);
    end
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tl_o.a_ready !== 1'b1 || tl_o.d_data !== 32'h0000_BBBB
        || tl_o.d_source !== 8'h71) begin
      failures++;
      $display("FAIL b2b_rsp1 a_ready=%b data=%h src=%h required 1 0000bbbb 71",
               tl_o.a_ready, tl_o.d_data, tl_o.d_source);
    end
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    checks++;
    if (tl_o.d_valid !== 1'b1 || tl_o.d_data !== 32'h0000_CCCC
        || tl_o.d_source !== 8'h72) begin
      failures++;
      $display("FAIL b2b_rsp2 d_valid=%b data=%h src=%h required 1 0000cccc 72",
               tl_o.d_valid, tl_o.d_data, tl_o.d_source);
    end
    @(negedge clk);
    checks++;
    if (tl_o.d_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain d_valid=%b required=0", tl_o.d_valid);
    end
    tl_i.d_ready = 1'b0;
  endtask

  task automatic test_errors();
    issue(PutFullData, 32'h1000_0000, 2'd2, 4'hF, 32'h0BAD_F00D, 8'h80);
    take();
    issue(Get, 32'h1000_1000, 2'd2, 4'hF, 32'h0, 8'h81);
    take();
    checks++;
    if (r_err !== 1'b1 || r_data !== 32'h0 || r_op !== AccessAckData) begin
      failures++;
      $display("FAIL err_range err=%b data=%h op=%0d required 1 0 1", r_err, r_data, r_op);
    end
    issue(Get, 32'h1000_0002, 2'd2, 4'hF, 32'h0, 8'h82);
    take();
    checks++;
    if (r_err !== 1'b1 || r_data !== 32'h0 || r_src !== 8'h82) begin
      failures++;
      $display("FAIL err_align err=%b data=%h src=%h required 1 0 82", r_err, r_data, r_src);
    end
    issue(3'd3, 32'h1000_0000, 2'd2, 4'hF, 32'hFFFF_FFFF, 8'h83);
    take();
    checks++;
    if (r_err !== 1'b1 || r_data !== 32'h0 || r_op !== AccessAck) begin
      failures++;
      $display("FAIL err_opcode err=%b data=%h op=%0d required 1 0 0", r_err, r_data, r_op);
    end
    issue(PutFullData, 32'h1000_0000, 2'd2, 4'h3, 32'h1234_5678, 8'h84);
    take();
    checks++;
    if (r_err !== 1'b1) begin
      failures++;
      $display("FAIL err_pfmask err=%b required=1", r_err);
    end
    issue(Get, 32'h1000_0000, 2'd3, 4'hF, 32'h0, 8'h85);
    take();
    checks++;
    if (r_err !== 1'b1 || r_size !== 2'd3) begin
      failures++;
      $display("FAIL err_size err=%b size=%0d required 1 3", r_err, r_size);
    end
    issue(Get, 32'h1000_0000, 2'd2, 4'hF, 32'h0, 8'h86);
    take();
    checks++;
    if (r_err !== 1'b0 || r_data !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL err_memkeep err=%b data=%h required 0 0badf00d", r_err, r_data);
    end
  endtask

  task automatic test_stream();
    logic [7:0]  esrc;
    logic [31:0] edata;
    logic [2:0]  eop;
    tl_i.d_ready = 1'b1;
    set_a(PutFullData, 32'h1000_0000, 2'd2, 4'hF, 32'hC0DE_0000, 8'h40);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      esrc  = 8'(8'h40 + k - 1);
      eop   = (k - 1 < 16) ? AccessAck : AccessAckData;
      edata = (k - 1 < 16) ? 32'h0 : (32'hC0DE_0000 | 32'(k - 17));
      checks++;
      if (tl_o.a_ready !== 1'b1 || tl_o.d_valid !== 1'b1 || tl_o.d_source !== esrc
          || tl_o.d_opcode !== eop || tl_o.d_data !== edata || tl_o.d_error !== 1'b0) begin
        failures++;
        $display("FAIL stream%0d a_ready=%b d_valid=%b src=%h op=%0d data=%h err=%b required 1 1 %h %0d %h 0",
                 k - 1, tl_o.a_ready, tl_o.d_valid, tl_o.d_source, tl_o.d_opcode,
                 tl_o.d_data, tl_o.d_error, esrc, eop, edata);
      end
      if (k < 16)
        set_a(PutFullData, 32'h1000_0000 + 32'(k * 4), 2'd2, 4'hF,
              32'hC0DE_0000 | 32'(k), 8'(8'h40 + k));
      else if (k < 32)
        set_a(Get, 32'h1000_0000 + 32'((k - 16) * 4), 2'd2, 4'hF,
              32'h0, 8'(8'h40 + k));
      else
        tl_i.a_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (tl_o.d_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain d_valid=%b required=0", tl_o.d_valid);
    end
    tl_i.d_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_raw();
    test_back_to_back();
    test_errors();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
